// File: rtl/subleq_datapath_if.sv
// Control/RAM bus between the SUBLEQ control unit (master) and datapath (slave).
// Optional halt status line exists only when SUBLEQ_HALT_EN is defined.
interface subleq_datapath_if #(
   parameter int DW = 8,
   parameter int AW = 8
);
   logic [2:0]    adr_reg_sel;
   logic          adr_dir;
   logic [2:0]    dat_reg_sel;
   logic          dat_dir;
   logic          ram_ope;
   logic          ram_ctl;
   logic [1:0]    pc_mod;
   logic [DW-1:0] ram_dat_in;
   logic [AW-1:0] ram_adr;
   logic          adr_oe;
   logic [DW-1:0] ram_dat_out;
   logic          dat_oe;
   logic [DW-1:0] sub_out;
   logic          sub_val;
   logic [AW-1:0] pc;
`ifdef SUBLEQ_HALT_EN
   logic          halt;
`endif

   modport slave (
      input  adr_reg_sel, adr_dir, dat_reg_sel, dat_dir, ram_ope, ram_ctl,
             pc_mod, ram_dat_in,
      output ram_adr, adr_oe, ram_dat_out, dat_oe, sub_out, sub_val, pc
`ifdef SUBLEQ_HALT_EN
      , output halt
`endif
   );

   modport master (
      output adr_reg_sel, adr_dir, dat_reg_sel, dat_dir, ram_ope, ram_ctl,
             pc_mod, ram_dat_in,
      input  ram_adr, adr_oe, ram_dat_out, dat_oe, sub_out, sub_val, pc
`ifdef SUBLEQ_HALT_EN
      , input halt
`endif
   );
endinterface

// File: rtl/subleq_datapath.sv
// SUBLEQ register/arithmetic datapath: PC, operand addresses A/B, branch
// target C, operand values, and the mem[B]-mem[A] subtractor.
// Optional macro SUBLEQ_HALT_EN adds a sticky halt on a branch-to-self.
module subleq_datapath #(
   parameter int DW       = 8,
   parameter int AW       = 8,
   parameter int RESET_PC = 0
) (
   input  logic             clk,
   input  logic             res,
   subleq_datapath_if.slave bus
);
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
   logic [DW-1:0] va_q, va_d, vb_q, vb_d;
   logic [DW-1:0] sub_q, sub_d;
   logic          val_q, val_d;
   // pend_q: an operand was loaded on the previous edge, so recompute now
   logic          pend_q, pend_d;
   logic          halted_q, halted_d;
   logic          ld, ld_op;

   // Next-state: loads, subtractor pipeline and PC sequencing
   always_comb begin
      ld    = bus.dat_dir & ~bus.ram_ope & bus.ram_ctl;
      ld_op = ld && (bus.dat_reg_sel == 3'd1 || bus.dat_reg_sel == 3'd2);
      pc_d     = pc_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      va_d     = va_q;
      vb_d     = vb_q;
      sub_d    = sub_q;
      val_d    = val_q;
      pend_d   = pend_q;
      halted_d = halted_q;
      if (ld) begin
         case (bus.dat_reg_sel)
            3'd0:    a_d  = bus.ram_dat_in[AW-1:0];
            3'd1:    va_d = bus.ram_dat_in;
            3'd2:    vb_d = bus.ram_dat_in;
            3'd3:    c_d  = bus.ram_dat_in[AW-1:0];
            3'd4:    b_d  = bus.ram_dat_in[AW-1:0];
            default: ;
         endcase
      end
      // Subtract uses pre-edge operands even if one is reloaded this edge
      if (pend_q) sub_d = vb_q - va_q;
      if (ld_op) begin
         val_d  = 1'b0;
         pend_d = 1'b1;
      end else if (pend_q) begin
         val_d  = 1'b1;
         pend_d = 1'b0;
      end
      // PC takes the pre-edge reg_c when a branch coincides with a C load
      if (!halted_q) begin
         case (bus.pc_mod)
            2'd1:    pc_d = pc_q + AW'(1);
            2'd2:    pc_d = c_q;
            default: ;
         endcase
      end
`ifdef SUBLEQ_HALT_EN
      if (bus.pc_mod == 2'd2 && c_q == AW'(pc_q - AW'(3))) halted_d = 1'b1;
`endif
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (res) begin
         pc_q     <= AW'(RESET_PC);
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         va_q     <= '0;
         vb_q     <= '0;
         sub_q    <= '0;
         val_q    <= 1'b0;
         pend_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         va_q     <= va_d;
         vb_q     <= vb_d;
         sub_q    <= sub_d;
         val_q    <= val_d;
         pend_q   <= pend_d;
         halted_q <= halted_d;
      end
   end

   // Address and store-data muxes are combinational from the registers
   always_comb begin
      case (bus.adr_reg_sel)
         3'd1:    bus.ram_adr = a_q;
         3'd2:    bus.ram_adr = b_q;
         3'd3:    bus.ram_adr = c_q;
         default: bus.ram_adr = pc_q;
      endcase
      case (bus.dat_reg_sel)
         3'd0:    bus.ram_dat_out = va_q;
         3'd1:    bus.ram_dat_out = vb_q;
         3'd2:    bus.ram_dat_out = DW'(c_q);
         3'd3:    bus.ram_dat_out = DW'(pc_q);
         3'd4:    bus.ram_dat_out = sub_q;
         default: bus.ram_dat_out = '0;
      endcase
   end

   assign bus.adr_oe  = ~bus.adr_dir;
   assign bus.dat_oe  = ~bus.dat_dir;
   assign bus.sub_out = sub_q;
   assign bus.sub_val = val_q;
   assign bus.pc      = pc_q;
`ifdef SUBLEQ_HALT_EN
   assign bus.halt    = halted_q;
`endif
endmodule

// File: tb/tb_subleq_datapath.sv
// Bench for subleq_datapath: directed scenarios plus random traffic checked
// against a behavioural model of the datapath registers.
module tb_subleq_datapath;
   logic clk = 1'b0;
   logic res = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   subleq_datapath_if #(.DW(8), .AW(8)) bus ();
   subleq_datapath #(.DW(8), .AW(8), .RESET_PC(0)) dut (
      .clk(clk), .res(res), .bus(bus));

   always #5 clk = ~clk;

   // model state
   logic [7:0] m_pc, m_a, m_b, m_c, m_va, m_vb, m_sub;
   logic       m_val, m_loaded_last, m_halt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_adr();
      case (bus.adr_reg_sel)
         3'd1: return m_a;
         3'd2: return m_b;
         3'd3: return m_c;
         default: return m_pc;
      endcase
   endfunction

   function automatic logic [7:0] exp_dout();
      case (bus.dat_reg_sel)
         3'd0: return m_va;
         3'd1: return m_vb;
         3'd2: return m_c;
         3'd3: return m_pc;
         3'd4: return m_sub;
         default: return 8'h00;
      endcase
   endfunction

   // apply the architectural rules for one rising edge
   task automatic model_edge();
      logic       ld, ld_op;
      logic [7:0] opc, oc, ova, ovb;
      if (res) begin
         m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_va = 0; m_vb = 0; m_sub = 0;
         m_val = 0; m_loaded_last = 0; m_halt = 0;
         return;
      end
      opc = m_pc; oc = m_c; ova = m_va; ovb = m_vb;
      ld    = bus.dat_dir && !bus.ram_ope && bus.ram_ctl;
      ld_op = ld && (bus.dat_reg_sel == 1 || bus.dat_reg_sel == 2);
      if (m_loaded_last) m_sub = ovb - ova;
      if (ld_op) m_val = 0;
      else if (m_loaded_last) m_val = 1;
      m_loaded_last = ld_op;
      if (!m_halt) begin
         if (bus.pc_mod == 1) m_pc = opc + 8'd1;
         else if (bus.pc_mod == 2) m_pc = oc;
      end
`ifdef SUBLEQ_HALT_EN
      if (bus.pc_mod == 2 && oc == opc - 8'd3) m_halt = 1;
`endif
      if (ld) begin
         case (bus.dat_reg_sel)
            3'd0: m_a  = bus.ram_dat_in;
            3'd1: m_va = bus.ram_dat_in;
            3'd2: m_vb = bus.ram_dat_in;
            3'd3: m_c  = bus.ram_dat_in;
            3'd4: m_b  = bus.ram_dat_in;
            default: ;
         endcase
      end
   endtask

   task automatic check_all();
      chk("pc", bus.pc, m_pc);
      chk("sub_out", bus.sub_out, m_sub);
      chk("sub_val", bus.sub_val, m_val);
      chk("ram_adr", bus.ram_adr, exp_adr());
      chk("adr_oe", bus.adr_oe, !bus.adr_dir);
      chk("ram_dat_out", bus.ram_dat_out, exp_dout());
      chk("dat_oe", bus.dat_oe, !bus.dat_dir);
`ifdef SUBLEQ_HALT_EN
      chk("halt", bus.halt, m_halt);
`endif
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle();
      bus.adr_reg_sel = 0; bus.adr_dir = 0; bus.dat_reg_sel = 0;
      bus.dat_dir = 1; bus.ram_ope = 1; bus.ram_ctl = 1; bus.pc_mod = 0;
      bus.ram_dat_in = 0;
   endtask

   task automatic load(input logic [2:0] sel, input logic [7:0] v, input logic [1:0] pm);
      bus.dat_dir = 1; bus.ram_ope = 0; bus.ram_ctl = 1;
      bus.dat_reg_sel = sel; bus.ram_dat_in = v; bus.pc_mod = pm;
      cycle();
      idle();
   endtask

   task automatic branch();
      bus.pc_mod = 2; cycle(); bus.pc_mod = 0;
   endtask

   initial begin
      idle();
      res = 1;
      cycle(); cycle();
      chk("rst_pc", bus.pc, 8'h00);
      chk("rst_val", bus.sub_val, 1'b0);
      res = 0;

      // reset mid-instruction with PC=0x37
      load(3, 8'h37, 0); branch();
      chk("pc_37", bus.pc, 8'h37);
      load(1, 8'h44, 0);
      bus.dat_dir = 1; bus.ram_ope = 0; bus.ram_ctl = 1; bus.dat_reg_sel = 2;
      bus.ram_dat_in = 8'h99; bus.pc_mod = 1; res = 1;
      cycle();
      chk("rst1_pc", bus.pc, 8'h00);
      chk("rst1_sub", bus.sub_out, 8'h00);
      chk("rst1_val", bus.sub_val, 1'b0);
      chk("rst1_doe", bus.dat_oe, 1'b0);
      cycle();
      res = 0; idle();

      // subtract 3 - 5
      load(1, 8'h05, 0);
      load(2, 8'h03, 0);
      chk("sub_val_ld", bus.sub_val, 1'b0);
      cycle();
      chk("sub_fe", bus.sub_out, 8'hFE);
      chk("sub_val1", bus.sub_val, 1'b1);
      cycle();
      chk("sub_hold", bus.sub_val, 1'b1);
      load(1, 8'h09, 0);
      chk("sub_val_clr", bus.sub_val, 1'b0);

      // address mux sweep
      load(0, 8'h10, 0); load(4, 8'h20, 0); load(3, 8'h40, 0); branch();
      load(3, 8'h30, 0);
      for (int s = 0; s < 8; s++) begin
         logic [7:0] ea;
         bus.adr_reg_sel = 3'(s); #1;
         ea = (s == 1) ? 8'h10 : (s == 2) ? 8'h20 : (s == 3) ? 8'h30 : 8'h40;
         chk("adr_sweep", bus.ram_adr, ea);
         check_all();
      end
      bus.adr_dir = 1; #1;
      chk("adr_oe0", bus.adr_oe, 1'b0);
      idle();

      // PC wrap, branch, branch with simultaneous C load
      load(3, 8'hFF, 0); branch();
      bus.pc_mod = 1; cycle(); bus.pc_mod = 0;
      chk("pc_wrap", bus.pc, 8'h00);
      load(3, 8'h80, 0); branch();
      chk("pc_80", bus.pc, 8'h80);
      load(3, 8'h90, 2);
      chk("pc_oldc", bus.pc, 8'h80);
      bus.adr_reg_sel = 3; #1;
      chk("c_new", bus.ram_adr, 8'h90);
      idle();

      // store of sub_out = 0x80 - 0x01
      load(1, 8'h01, 0); load(2, 8'h80, 0); cycle();
      bus.dat_dir = 0; bus.dat_reg_sel = 4; bus.ram_ope = 1; bus.ram_ctl = 0;
      bus.ram_dat_in = 8'h5A;
      cycle();
      chk("st_dat", bus.ram_dat_out, 8'h7F);
      chk("st_oe", bus.dat_oe, 1'b1);
      bus.ram_ctl = 1; cycle();
      bus.ram_ope = 0; cycle();
      for (int s = 0; s < 8; s++) begin
         bus.dat_reg_sel = 3'(s); #1; check_all();
      end
      idle();

`ifdef SUBLEQ_HALT_EN
      load(3, 8'h06, 0); branch();
      load(3, 8'h03, 0); branch();
      chk("h_pc", bus.pc, 8'h03);
      chk("h_set", bus.halt, 1'b1);
      bus.pc_mod = 1; cycle(); cycle(); cycle(); bus.pc_mod = 0;
      chk("h_stay", bus.pc, 8'h03);
      res = 1; cycle(); res = 0;
      chk("h_clr", bus.halt, 1'b0);
`endif

      // random traffic
      for (int i = 0; i < 600; i++) begin
         res = ($urandom_range(0, 49) == 0);
         bus.adr_reg_sel = 3'($urandom);
         bus.adr_dir     = 1'($urandom);
         bus.dat_reg_sel = 3'($urandom);
         bus.dat_dir     = ($urandom_range(0, 3) != 0);
         bus.ram_ope     = 1'($urandom);
         bus.ram_ctl     = ($urandom_range(0, 3) != 0);
         bus.pc_mod      = 2'($urandom);
         bus.ram_dat_in  = 8'($urandom);
         cycle();
      end
      res = 0; idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/subleq_datapath.md
Name: subleq_datapath

Overview:
- Register/arithmetic datapath for the SUBLEQ machine.
- Holds the program counter (PC), operand A address, operand B address, branch target C, and the fetched operand values.
- Computes mem[B] - mem[A] and drives RAM address and write data.
- Sits directly downstream of the control unit: consumes its select/direction/strobe/pc_mod outputs and returns sub_out/sub_val.

Parameters:
- DW, 8, data and register width.
- AW, 8, address width; PC and address registers are AW bits.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- res  input  1  synchronous reset, active-high.
- adr_reg_sel  input  3  address source: 0 PC, 1 reg_a, 2 reg_b, 3 reg_c, 4-7 PC.
- adr_dir  input  1  0: datapath drives ram_adr (adr_oe=1); 1: adr_oe=0.
- dat_reg_sel  input  3  register target for a load, or source for a store.
- dat_dir  input  1  1: load RAM data into a register; 0: drive ram_dat_out.
- ram_ope  input  1  0: RAM read cycle; 1: write/idle.
- ram_ctl  input  1  write strobe, active-low.
- pc_mod  input  2  0 hold, 1 increment, 2 load reg_c, 3 hold.
- ram_dat_in  input  DW  data read from RAM.
- ram_adr  output  AW  RAM address.
- adr_oe  output  1  address drive enable (= ~adr_dir).
- ram_dat_out  output  DW  write data to RAM.
- dat_oe  output  1  write data drive enable.
- sub_out  output  DW  registered mem[B] - mem[A].
- sub_val  output  1  sub_out valid.
- pc  output  AW  current PC, for debug.

Behaviour:
- Reset (res=1 at edge): PC=RESET_PC; reg_a, reg_b, reg_c, reg_va, reg_vb, sub_out = 0; sub_val=0; halted=0. Reset overrides every other input, including mid-instruction.
- Load: fires when dat_dir=1, ram_ope=0 and ram_ctl=1 at the edge; ram_dat_in is captured into the register selected by dat_reg_sel:
  - 0 reg_a
  - 1 reg_va
  - 2 reg_vb
  - 3 reg_c
  - 4 reg_b
  - 5-7 no effect
- Store: dat_oe=1 when dat_dir=0. ram_dat_out source by dat_reg_sel:
  - 0 reg_va
  - 1 reg_vb
  - 2 reg_c
  - 3 PC zero-extended/truncated to DW
  - 4 sub_out
  - 5-7 0
  - ram_dat_out is combinational from the registers.
- ram_adr: combinational mux on adr_reg_sel.
- Subtractor:
  - Any load into reg_va or reg_vb clears sub_val on that edge.
  - Next edge: sub_out <= reg_vb - reg_va, modulo 2^DW two's complement; sub_val <= 1.
  - Latency: 1 clock after the last operand load.
  - sub_val holds until the next operand load or reset.
- PC update:
  - pc_mod=1: PC <= PC+1, wraps from 2^AW-1 to 0.
  - pc_mod=2: PC <= reg_c.
- Simultaneous load of reg_c and pc_mod=2 on the same edge: PC takes the old reg_c; reg_c takes the new value.
- Simultaneous load of reg_vb and sub_out update: sub_out computes from the old values; sub_val=0 after the edge.
- A store cycle (dat_dir=0) never modifies any register.

Optional Feature:
- Macro SUBLEQ_HALT_EN.
- When defined, one extra state bit halted is added:
  - Set when pc_mod=2 and reg_c equals PC-3 modulo 2^AW, i.e. a branch to the current instruction (SUBLEQ self-loop halt idiom).
  - While halted, PC ignores pc_mod.
  - Output port halt (1 bit) equals halted.
  - Cleared only by res.
- When undefined: no halt port and no halted state; pc_mod is always honoured.

Test Plan:
- Reset: res=1 for 2 clocks mid-sequence with PC=0x37 -> PC=0x00, sub_out=0x00, sub_val=0, dat_oe=0 on the first edge with res=1.
- Subtract: load reg_va=0x05, then reg_vb=0x03 -> one clock later sub_out=0xFE, sub_val=1; sub_val=0 on the edge that loads the next reg_va.
- Address mux: reg_a=0x10, reg_b=0x20, reg_c=0x30, PC=0x40; sweep adr_reg_sel 0..7 -> ram_adr = 0x40, 0x10, 0x20, 0x30, then 0x40 for 4-7; adr_dir=1 -> adr_oe=0.
- PC: PC=0xFF, pc_mod=1 -> 0x00. Load reg_c=0x80, pc_mod=2 -> PC=0x80. Same-edge reg_c load 0x90 with pc_mod=2 and old reg_c=0x80 -> PC=0x80, reg_c=0x90.
- Store: sub_out=0x7F, dat_dir=0, dat_reg_sel=4, ram_ctl pulsed low -> ram_dat_out=0x7F, dat_oe=1, all registers unchanged.
- SUBLEQ_HALT_EN: PC=0x06, reg_c=0x03, pc_mod=2 -> PC=0x03, halt=1; then pc_mod=1 for 3 clocks -> PC stays 0x03; res=1 -> halt=0.
